sort4_serializer: RTL and testbench

- Downstream stage of the 4-input, 16-bit sorting network. Accepts one parallel sorted 4-word frame per handshake and emits it as a serial word stream over a valid/ready interface.
- Includes a 2-frame ping-pong buffer, so the sorter can deliver back-to-back frames while the consumer stalls.
- Also checks that each frame is actually sorted and counts completed frames.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort4_serializer_if.sv | 32 +++
 rtl/sort4_frame_buf.sv | 58 +++++
 rtl/sort4_serializer.sv | 81 ++++++++
 tb/tb_sort4_serializer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg
// Description : Shared constants and frame type for the 4-lane sorter and its
//               serializer.
// Revision    : 1.0  initial release
// ============================================================================
package sort_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int NUM_LANES = 4;

    typedef logic [NUM_LANES-1:0][DEF_WIDTH-1:0] frame_t;

    // Word index for a beat; descending order walks the frame from the top.
    function automatic logic [1:0] lane_sel(input logic [1:0] beat, input logic descend);
        return descend ? ~beat : beat;
    endfunction
endpackage
`default_nettype wire

// File: rtl/sort4_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sort4_serializer_if
// Description : Parallel-in / serial-out handshake bundle of the serializer.
// Revision    : 1.0  initial release
// ============================================================================
interface sort4_serializer_if import sort_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sort4_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : sort4_frame_buf
// Description : Two-entry ping-pong FIFO holding whole 4-word frames.
// Revision    : 1.0  initial release
// ============================================================================
module sort4_frame_buf import sort_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic                               clock,
    input  wire logic                               reset,
    input  wire logic                               push_i,
    input  wire logic                               pop_i,
    input  wire logic [NUM_LANES-1:0][WIDTH-1:0]    wdata_i,
    output logic      [NUM_LANES-1:0][WIDTH-1:0]    rdata_o,
    output logic                                    in_ready_o,
    output logic                                    not_empty_o
);
    logic [NUM_LANES-1:0][WIDTH-1:0] mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;

    // Frame storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign in_ready_o  = (count_q != 2'd2);
    assign not_empty_o = (count_q != 2'd0);
endmodule
`default_nettype wire

// File: rtl/sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sort4_serializer
// Description : Buffers sorted 4-word frames and streams them word by word,
//               flagging unsorted frames and counting completed ones.
// Revision    : 1.0  initial release
// ============================================================================
module sort4_serializer import sort_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter bit DESCEND = 1'b0,
    parameter int CNT_W   = 16
) (
    input  wire logic              clock,
    input  wire logic              reset,
    sort4_serializer_if.slave      bus,
    output logic                   order_err,
    output logic [CNT_W-1:0]       frame_cnt
);
    logic [NUM_LANES-1:0][WIDTH-1:0] w_wdata, w_rdata;
    logic             w_in_ready, w_not_empty;
    logic             w_push, w_xfer, w_pop, w_unsorted;
    logic [1:0]       w_lane;
    logic [1:0]       beat_q, beat_d;
    logic             order_err_q, order_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    assign w_wdata = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
    assign w_push  = bus.in_valid && w_in_ready;
    assign w_xfer  = w_not_empty && bus.out_ready;
    assign w_pop   = w_xfer && (beat_q == 2'd3);

    sort4_frame_buf #(.WIDTH(WIDTH)) u_frame_buf (
        .clock       (clock),
        .reset       (reset),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .wdata_i     (w_wdata),
        .rdata_o     (w_rdata),
        .in_ready_o  (w_in_ready),
        .not_empty_o (w_not_empty)
    );

    // Unsigned non-decreasing check; equal neighbours are legal.
    assign w_unsorted = !((bus.in_data0 <= bus.in_data1) &&
                          (bus.in_data1 <= bus.in_data2) &&
                          (bus.in_data2 <= bus.in_data3));

    always_comb begin
        beat_d      = beat_q;
        order_err_d = order_err_q | (w_push && w_unsorted);
        frame_cnt_d = frame_cnt_q;
        if (w_xfer) begin
            beat_d = beat_q + 2'd1;
        end
        if (w_pop) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_q      <= 2'd0;
            order_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            beat_q      <= beat_d;
            order_err_q <= order_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign w_lane        = lane_sel(beat_q, DESCEND);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_not_empty;
    assign bus.out_data  = w_rdata[w_lane];
    assign bus.out_idx   = beat_q;
    assign bus.out_last  = w_not_empty && (beat_q == 2'd3);
    assign order_err     = order_err_q;
    assign frame_cnt     = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort4_serializer
// Description : Ascending and descending serializers driven in lockstep and
//               checked against a frame-queue model of the output stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sort4_serializer;
    typedef logic [3:0][15:0] frm_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;

    always #5 clock = ~clock;

    sort4_serializer_if #(.WIDTH(16)) bus_a ();
    sort4_serializer_if #(.WIDTH(16)) bus_d ();

    assign bus_a.in_valid = in_valid;  assign bus_d.in_valid = in_valid;
    assign bus_a.out_ready = out_ready; assign bus_d.out_ready = out_ready;
    assign bus_a.in_data0 = d0; assign bus_a.in_data1 = d1;
    assign bus_a.in_data2 = d2; assign bus_a.in_data3 = d3;
    assign bus_d.in_data0 = d0; assign bus_d.in_data1 = d1;
    assign bus_d.in_data2 = d2; assign bus_d.in_data3 = d3;

    logic        err_a, err_d;
    logic [15:0] cnt_a, cnt_d;

    sort4_serializer #(.WIDTH(16), .DESCEND(1'b0), .CNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave), .order_err(err_a), .frame_cnt(cnt_a));
    sort4_serializer #(.WIDTH(16), .DESCEND(1'b1), .CNT_W(16)) u_dut_d (
        .clock(clock), .reset(reset), .bus(bus_d.slave), .order_err(err_d), .frame_cnt(cnt_d));

    // Model: queue of buffered frames, position within the head frame.
    frm_t mq[$];
    int   m_beat = 0;
    int   m_cnt = 0;
    bit   m_err = 1'b0;
    bit   m_pushed = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                m_beat = 0; m_err = 1'b0; m_pushed = 1'b0; m_cnt = 0;
            end else begin
                bit   do_push;
                frm_t f;
                do_push = in_valid && (mq.size() < 2);
                f = {d3, d2, d1, d0};
                if (mq.size() > 0 && out_ready) begin
                    if (m_beat == 3) begin
                        void'(mq.pop_front());
                        m_beat = 0;
                        m_cnt++;
                    end else begin
                        m_beat++;
                    end
                end
                if (do_push) begin
                    mq.push_back(f);
                    if (!(d0 <= d1 && d1 <= d2 && d2 <= d3)) m_err = 1'b1;
                end
                m_pushed = do_push;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("a_in_ready",  bus_a.in_ready,  mq.size() != 2);
            chk("d_in_ready",  bus_d.in_ready,  mq.size() != 2);
            chk("a_out_valid", bus_a.out_valid, mq.size() != 0);
            chk("d_out_valid", bus_d.out_valid, mq.size() != 0);
            chk("a_out_idx",   bus_a.out_idx,   m_beat);
            chk("d_out_idx",   bus_d.out_idx,   m_beat);
            chk("a_out_last",  bus_a.out_last,  mq.size() != 0 && m_beat == 3);
            chk("d_out_last",  bus_d.out_last,  mq.size() != 0 && m_beat == 3);
            chk("a_order_err", err_a, m_err);
            chk("d_order_err", err_d, m_err);
            chk("a_frame_cnt", cnt_a, m_cnt[15:0]);
            chk("d_frame_cnt", cnt_d, m_cnt[15:0]);
            if (mq.size() != 0) begin
                chk("a_out_data", bus_a.out_data, mq[0][m_beat]);
                chk("d_out_data", bus_d.out_data, mq[0][3 - m_beat]);
            end
        end
    end

    task automatic set_data(input logic [15:0] w0, w1, w2, w3);
        d0 = w0; d1 = w1; d2 = w2; d3 = w3;
    endtask

    task automatic push(input logic [15:0] w0, w1, w2, w3);
        @(posedge clock); #1;
        set_data(w0, w1, w2, w3);
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge clock); #1;
            if (m_pushed) break;
        end
        chk("push_accept", m_pushed, 1'b1);
        in_valid = 1'b0;
    endtask

    // Literal expectations for a frame streaming with out_ready held high.
    task automatic check_frame(input logic [15:0] w0, w1, w2, w3);
        logic [15:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("lit_a_data", bus_a.out_data, w[k]);
            chk("lit_d_data", bus_d.out_data, w[3 - k]);
            chk("lit_idx",    bus_a.out_idx,  k);
            chk("lit_last",   bus_a.out_last, k == 3);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            if (mq.size() == 0) break;
            @(posedge clock); #1;
        end
        chk("drain", mq.size(), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  bus_a.in_ready, 1'b1);
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_out_last",  bus_a.out_last, 1'b0);
        chk("rst_out_idx",   bus_a.out_idx, 2'd0);
        chk("rst_cnt",       cnt_a, 16'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Single frame in both orders.
        out_ready = 1'b1;
        push(16'd1, 16'd2, 16'd3, 16'd4);
        check_frame(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clock);
        chk("lit_cnt_one", cnt_a, 16'd1);
        chk("lit_err_zero", err_a, 1'b0);
        push(16'h0010, 16'h0020, 16'h0030, 16'hFFFF);
        check_frame(16'h0010, 16'h0020, 16'h0030, 16'hFFFF);

        // Backpressure with three back-to-back frames.
        @(posedge clock); #1;
        out_ready = 1'b0;
        set_data(16'd11, 16'd12, 16'd13, 16'd14); in_valid = 1'b1;
        @(posedge clock); #1 set_data(16'd21, 16'd22, 16'd23, 16'd24);
        @(posedge clock); #1 set_data(16'd31, 16'd32, 16'd33, 16'd34);
        @(negedge clock);
        chk("bp_in_ready", bus_a.in_ready, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("bp_hold_data", bus_a.out_data, 16'd11);
            chk("bp_hold_idx",  bus_a.out_idx, 2'd0);
        end
        @(posedge clock); #1 out_ready = 1'b1;
        for (t = 1; t <= 20; t++) begin
            @(posedge clock); #1;
            if (m_pushed) break;
        end
        chk("bp_push_edge", t, 5);
        in_valid = 1'b0;
        wait_idle();

        // Push into count 1 on the same edge as the last beat pops.
        push(16'd40, 16'd41, 16'd42, 16'd43);
        repeat (3) @(negedge clock);
        @(negedge clock);
        chk("sim_last", bus_a.out_last, 1'b1);
        set_data(16'd50, 16'd51, 16'd52, 16'd53); in_valid = 1'b1;
        @(posedge clock); #1;
        chk("sim_push", m_pushed, 1'b1);
        in_valid = 1'b0;
        @(negedge clock);
        chk("sim_next_data", bus_a.out_data, 16'd50);
        chk("sim_next_idx",  bus_a.out_idx, 2'd0);
        chk("sim_in_ready",  bus_a.in_ready, 1'b1);
        wait_idle();

        // Unsorted frame sets the sticky flag and still streams unchanged.
        push(16'd5, 16'd3, 16'd7, 16'd9);
        chk("lit_err_set", err_a, 1'b1);
        check_frame(16'd5, 16'd3, 16'd7, 16'd9);
        push(16'd2, 16'd2, 16'd2, 16'd2);
        check_frame(16'd2, 16'd2, 16'd2, 16'd2);
        chk("lit_err_sticky", err_a, 1'b1);
        @(posedge clock); #2 reset = 1'b0;
        #1 chk("lit_err_clr", err_a, 1'b0);
        @(posedge clock); #1 reset = 1'b1;

        // Asynchronous reset after beat 1.
        push(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clock);
        @(negedge clock);
        chk("ar_beat1", bus_a.out_data, 16'd2);
        @(posedge clock); #2 reset = 1'b0;
        #1;
        chk("ar_valid_a", bus_a.out_valid, 1'b0);
        chk("ar_valid_d", bus_d.out_valid, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("ar_in_ready", bus_a.in_ready, 1'b1);
        chk("ar_cnt", cnt_a, 16'd0);
        repeat (6) begin
            @(negedge clock);
            chk("ar_no_stale", bus_a.out_valid, 1'b0);
        end

        // Randomized traffic; a held frame keeps its data until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (!in_valid || m_pushed) begin
                logic [15:0] v[4];
                logic [15:0] tmp;
                bit narrow;
                narrow = ($urandom % 4) == 0;
                for (int i = 0; i < 4; i++)
                    v[i] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
                if (($urandom % 8) != 0) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (v[j] > v[j+1]) begin
                                tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
                            end
                end
                set_data(v[0], v[1], v[2], v[3]);
                in_valid = ($urandom % 100) < 60;
            end
            out_ready = ($urandom % 100) < 70;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
